// File: rtl/ldm_wb_sequencer.sv
// ldm_wb_sequencer: load-multiple sequencer for the memory/write-back stage.
// Issues one word read per listed register, writes each to the register file, then optionally the updated base.
`default_nettype none

module ldm_wb_sequencer #(
  parameter int DATA_W = 32,
  parameter int NREG   = 16,
  parameter int WORD_B = 4,
  localparam int IDX_W = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NREG-1:0]   reg_list,
  input  logic [DATA_W-1:0] base_addr,
  input  logic [IDX_W-1:0]  base_reg,
  input  logic              up,
  input  logic              wback,
  output logic              mem_rd_req,
  output logic [DATA_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [IDX_W-1:0]  destWB,
  output logic [DATA_W-1:0] resultWB,
  output logic              writeBackEn,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = IDX_W + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WB   = 3'd2;
  localparam logic [2:0] S_BASE = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        state;
  logic [NREG-1:0]   list_q;
  logic [NREG-1:0]   orig_list;
  logic [IDX_W-1:0]  base_reg_q;
  logic              wback_q;
  logic [DATA_W-1:0] cur_addr;
  logic [DATA_W-1:0] final_addr;

  logic [CNT_W-1:0]  start_cnt;
  logic [DATA_W-1:0] span;
  logic [DATA_W-1:0] first_addr;
  logic [DATA_W-1:0] last_addr;
  logic [IDX_W-1:0]  low_idx;
  logic [NREG-1:0]   low_mask;

  always_comb begin
    start_cnt = '0;
    for (int i = 0; i < NREG; i++) begin
      start_cnt = start_cnt + CNT_W'(reg_list[i]);
    end
    span       = DATA_W'(start_cnt) * DATA_W'(WORD_B);
    // Both modes place the lowest register at the lowest address, so DB starts below the base.
    first_addr = up ? base_addr : base_addr - span;
    last_addr  = up ? base_addr + span : base_addr - span;
  end

  always_comb begin
    low_idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (list_q[i]) begin
        low_idx = IDX_W'(i);
      end
    end
    low_mask = {{(NREG-1){1'b0}}, 1'b1} << low_idx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      list_q      <= '0;
      orig_list   <= '0;
      base_reg_q  <= '0;
      wback_q     <= 1'b0;
      cur_addr    <= '0;
      final_addr  <= '0;
      mem_rd_req  <= 1'b0;
      mem_addr    <= '0;
      destWB      <= '0;
      resultWB    <= '0;
      writeBackEn <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      writeBackEn <= 1'b0;
      done        <= 1'b0;
      case (state)
        S_IDLE: begin
          mem_rd_req <= 1'b0;
          busy       <= 1'b0;
          if (start) begin
            list_q     <= reg_list;
            orig_list  <= reg_list;
            base_reg_q <= base_reg;
            wback_q    <= wback;
            cur_addr   <= first_addr;
            final_addr <= last_addr;
            busy       <= 1'b1;
            if (start_cnt != '0) begin
              mem_rd_req <= 1'b1;
              mem_addr   <= first_addr;
              state      <= S_REQ;
            end else begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end

        S_REQ: begin
          // The write-back values are registered here so they are stable for the whole WB cycle.
          if (mem_ack) begin
            mem_rd_req  <= 1'b0;
            writeBackEn <= 1'b1;
            destWB      <= low_idx;
            resultWB    <= mem_rdata;
            list_q      <= list_q & ~low_mask;
            cur_addr    <= cur_addr + DATA_W'(WORD_B);
            state       <= S_WB;
          end
        end

        S_WB: begin
          if (list_q != '0) begin
            mem_rd_req <= 1'b1;
            mem_addr   <= cur_addr;
            state      <= S_REQ;
          end else if (wback_q && !orig_list[base_reg_q]) begin
            writeBackEn <= 1'b1;
            destWB      <= base_reg_q;
            resultWB    <= final_addr;
            state       <= S_BASE;
          end else begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end

        S_BASE: begin
          done  <= 1'b1;
          state <= S_DONE;
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          mem_rd_req <= 1'b0;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
